// File: rtl/xorshift_rng_stream.sv
// Xorshift pseudo-random generator with a valid/ready output stream, reseeding,
// warm-up discard and zero-state guard. Define RNG_DRAW_COUNT_EN to add the draw_count output.
module xorshift_rng_stream #(
  parameter int                STATE_W      = 32,
  parameter int                SEED_W       = 8,
  parameter int                OUT_W        = 8,
  parameter int                SH_A         = 13,
  parameter int                SH_B         = 17,
  parameter int                SH_C         = 5,
  parameter logic [SEED_W-1:0] DEFAULT_SEED = 8'hA5,
  parameter int                WARMUP       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [SEED_W-1:0] seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
`ifdef RNG_DRAW_COUNT_EN
  ,
  output logic [31:0]       draw_count
`endif
);

  typedef enum logic {WARM, READY} fsm_e;

  localparam int                 REP           = STATE_W / SEED_W;
  localparam fsm_e               START_FSM     = (WARMUP > 0) ? WARM : READY;
  localparam logic [STATE_W-1:0] DEFAULT_STATE = {REP{DEFAULT_SEED}};
  localparam logic [7:0]         WARM_LAST     = 8'(WARMUP - 1);

  function automatic logic [STATE_W-1:0] xs_next(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] s1;
    logic [STATE_W-1:0] s2;
    s1 = s ^ (s << SH_A);
    s2 = s1 ^ (s1 >> SH_B);
    return s2 ^ (s2 << SH_C);
  endfunction

  // A zero seed would lock xorshift at zero forever, so it falls back to the default.
  function automatic logic [STATE_W-1:0] expand_seed(input logic [SEED_W-1:0] sd);
    logic [SEED_W-1:0] eff;
    eff = (sd == '0) ? DEFAULT_SEED : sd;
    return {REP{eff}};
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         warm_cnt_q, warm_cnt_d;
  fsm_e               fsm_q, fsm_d;
  logic               accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DEFAULT_STATE;
      warm_cnt_q <= 8'd0;
      fsm_q      <= START_FSM;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      fsm_q      <= fsm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    fsm_d      = fsm_q;
    accept     = 1'b0;
    if (seed_load) begin
      state_d    = expand_seed(seed);
      warm_cnt_d = 8'd0;
      fsm_d      = START_FSM;
    end else begin
      case (fsm_q)
        WARM: begin
          state_d    = xs_next(state_q);
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_q == WARM_LAST) begin
            fsm_d = READY;
          end
        end
        READY: begin
          if (out_ready) begin
            accept  = 1'b1;
            state_d = xs_next(state_q);
          end
        end
        default: fsm_d = START_FSM;
      endcase
    end
  end

  // rst_n gates valid so it drops immediately even when reset parks the FSM in READY.
  assign out_valid = rst_n & (fsm_q == READY);
  assign busy      = (fsm_q == WARM);
  assign out_data  = state_q[OUT_W-1:0];

`ifdef RNG_DRAW_COUNT_EN
  logic [31:0] draw_count_q, draw_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_count_q <= 32'd0;
    end else begin
      draw_count_q <= draw_count_d;
    end
  end

  always_comb begin
    draw_count_d = draw_count_q;
    if (seed_load) begin
      draw_count_d = 32'd0;
    end else if (accept) begin
      draw_count_d = draw_count_q + 32'd1;
    end
  end

  assign draw_count = draw_count_q;
`endif

endmodule

// File: tb/tb_xorshift_rng_stream.sv
// Directed bench for xorshift_rng_stream: three instances cover WARMUP=0,
// the default warm-up and a 64-bit state with 16-bit output.
module tb_xorshift_rng_stream;

  logic clk;
  logic rst_n;

  logic       a_seed_load, a_valid, a_ready, a_busy;
  logic [7:0] a_seed, a_data;
  logic       b_seed_load, b_valid, b_ready, b_busy;
  logic [7:0] b_seed, b_data;
  logic       c_seed_load, c_valid, c_ready, c_busy;
  logic [7:0] c_seed;
  logic [15:0] c_data;
`ifdef RNG_DRAW_COUNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt;
`endif

  int checks = 0;
  int errors = 0;

  xorshift_rng_stream #(.WARMUP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .seed_load(a_seed_load), .seed(a_seed),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .busy(a_busy)
`ifdef RNG_DRAW_COUNT_EN
    , .draw_count(a_cnt)
`endif
  );

  xorshift_rng_stream u_b (
    .clk(clk), .rst_n(rst_n), .seed_load(b_seed_load), .seed(b_seed),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .busy(b_busy)
`ifdef RNG_DRAW_COUNT_EN
    , .draw_count(b_cnt)
`endif
  );

  xorshift_rng_stream #(.STATE_W(64), .OUT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .seed_load(c_seed_load), .seed(c_seed),
    .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data), .busy(c_busy)
`ifdef RNG_DRAW_COUNT_EN
    , .draw_count(c_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] seed;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] rec  [50];

  // Reference xorshift (13,17,5) for 32- or 64-bit state.
  function automatic logic [63:0] m_next(input logic [63:0] s, input int w);
    logic [63:0] mask;
    logic [63:0] s1;
    logic [63:0] s2;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s1 = (s ^ (s << 13)) & mask;
    s2 = s1 ^ (s1 >> 17);
    return (s2 ^ (s2 << 5)) & mask;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_c_warm(input string tag);
    int n;
    n = 0;
    while (c_busy && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_c_warm_cycles"}, 64'(n), 64'd8);
  endtask

  task automatic run_c50(input string tag);
    for (int i = 0; i < 50; i++) begin
      chk({tag, "_c_valid"}, 64'(c_valid), 64'd1);
      chk({tag, "_c_data"}, 64'(c_data), 64'(rec[i]));
      tick();
    end
  endtask

  initial begin
    logic [63:0] m;
    int          n;

    vecs[0] = '{8'h01, 8'h01, 8'hB1};
    vecs[1] = '{8'h00, 8'hA5, 8'h8D};
    vecs[2] = '{8'hFF, 8'hFF, 8'h1F};
    vecs[3] = '{8'h80, 8'h80, 8'hC8};

    rst_n = 1'b0;
    a_seed_load = 0; a_seed = 0; a_ready = 0;
    b_seed_load = 0; b_seed = 0; b_ready = 0;
    c_seed_load = 0; c_seed = 0; c_ready = 0;
    repeat (3) tick();

    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd1);
    chk("rst_c_valid", 64'(c_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_valid", 64'(a_valid), 64'd1);
    chk("post_rst_a_data", 64'(a_data), 64'hA5);

    // Table: reload seed with out_ready high, then one accepted step.
    for (int i = 0; i < 4; i++) begin
      a_seed_load = 1; a_seed = vecs[i].seed; a_ready = 1;
      tick();
      a_seed_load = 0;
      chk("vec_valid", 64'(a_valid), 64'd1);
      chk("vec_first", 64'(a_data), 64'(vecs[i].exp0));
      tick();
      chk("vec_second", 64'(a_data), 64'(vecs[i].exp1));
      $display("vector %0d seed %02h first %02h second %02h", i, vecs[i].seed, vecs[i].exp0, vecs[i].exp1);
    end
    a_ready = 0;

    // Zero seed -> default state, 1000 draws against the model.
    a_seed_load = 1; a_seed = 8'h00;
    tick();
    a_seed_load = 0; a_ready = 1;
    m = 64'hA5A5_A5A5;
    for (int i = 0; i < 1000; i++) begin
      chk("zero_seed_draw", 64'(a_data), 64'(m[7:0]));
      tick();
      m = m_next(m, 32);
    end
    $display("zero-seed run of 1000 draws done");

    // Backpressure for 20 cycles, then resume without skipping.
    a_ready = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", 64'(a_valid), 64'd1);
      chk("hold_data", 64'(a_data), 64'(m[7:0]));
    end
    a_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      m = m_next(m, 32);
      chk("resume_data", 64'(a_data), 64'(m[7:0]));
    end
    $display("backpressure hold and resume done");

    // seed_load coincident with an accept: reload wins, no advance.
    a_seed_load = 1; a_seed = 8'h01;
    tick();
    chk("reload_over_accept", 64'(a_data), 64'h01);
`ifdef RNG_DRAW_COUNT_EN
    chk("draw_count_cleared", 64'(a_cnt), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_reload", 64'(a_data), 64'h01);
    end
    a_seed_load = 0;
    tick();
    chk("after_reload_step", 64'(a_data), 64'hB1);
`ifdef RNG_DRAW_COUNT_EN
    chk("draw_count_one", 64'(a_cnt), 64'd1);
`endif
    a_ready = 0;
    $display("reload priority sequence done");

    // Warm-up on instance b: 8 busy cycles, then the 8th iterate.
    b_seed_load = 1; b_seed = 8'h3C; b_ready = 1;
    tick();
    b_seed_load = 0;
    n = 0;
    while (b_busy && n < 40) begin
      chk("warm_valid_low", 64'(b_valid), 64'd0);
      tick();
      n++;
    end
    chk("warm_cycles", 64'(n), 64'd8);
    chk("warm_done_valid", 64'(b_valid), 64'd1);
    m = 64'h3C3C_3C3C;
    for (int i = 0; i < 8; i++) m = m_next(m, 32);
    chk("warm_first", 64'(b_data), 64'(m[7:0]));
    tick();
    m = m_next(m, 32);
    chk("warm_second", 64'(b_data), 64'(m[7:0]));
    b_ready = 0;
    $display("warm-up sequence done, busy cycles %0d", n);

    // Instance c: power-up stream (held since reset) against the model.
    m = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int i = 0; i < 8; i++) m = m_next(m, 64);
    for (int i = 0; i < 50; i++) begin
      rec[i] = m[15:0];
      m = m_next(m, 64);
    end
    c_ready = 1;
    run_c50("pwr");
    $display("64-bit power-up stream of 50 draws done");

    // Reset mid-warm-up.
    c_seed_load = 1; c_seed = 8'h5A;
    tick();
    c_seed_load = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("rst_warm_valid", 64'(c_valid), 64'd0);
    chk("rst_warm_busy", 64'(c_busy), 64'd1);
    tick();
    rst_n = 1;
    wait_c_warm("rw");
    run_c50("rw");
    $display("reset mid-warm-up restart done");

    // Reset mid-stream with out_ready high.
    rst_n = 0;
    #1;
    chk("rst_stream_valid", 64'(c_valid), 64'd0);
    tick();
    rst_n = 1;
    wait_c_warm("rs");
    run_c50("rs");
    $display("reset mid-stream restart done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
